// File: rtl/cj_pkg.sv
// -----------------------------------------------------------------------------
// cj_pkg
// Shared constants and helpers for the clocked CJ join stage.
//   CJ_MAX_N_IN   : largest supported number of joined upstream channels
//   CJ_MAX_DEPTH  : largest supported token capacity
//   cj_cnt_w()    : occupancy counter width for a given depth
//   cj_occ_t      : occupancy type wide enough for CJ_MAX_DEPTH
//   CJ_ST_*       : encodings of the implicit EMPTY/PARTIAL/FULL state
// -----------------------------------------------------------------------------
package cj_pkg;

    localparam int CJ_MAX_N_IN  = 8;
    localparam int CJ_MAX_DEPTH = 16;

    function automatic int cj_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CJ_OCC_W = $clog2(CJ_MAX_DEPTH + 1);
    typedef logic [CJ_OCC_W-1:0] cj_occ_t;

    // The stage has no explicit state register; these name the state implied
    // by the occupancy count so that checks can talk about it directly.
    localparam logic [1:0] CJ_ST_EMPTY   = 2'd0;
    localparam logic [1:0] CJ_ST_PARTIAL = 2'd1;
    localparam logic [1:0] CJ_ST_FULL    = 2'd2;

endpackage

// File: rtl/cj_occ_counter.sv
// -----------------------------------------------------------------------------
// cj_occ_counter
// Saturating up/down token counter for the CJ join stage.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   inc      in   one token entered this cycle
//   dec      in   one token left this cycle
//   occ      out  current token count (0..DEPTH)
//   full     out  occ == DEPTH
//   empty    out  occ == 0
//   nz_next  out  count after the coming edge is non-zero
// inc and dec together leave the count unchanged.
// -----------------------------------------------------------------------------
module cj_occ_counter
    import cj_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = cj_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] occ,
    output logic             full,
    output logic             empty,
    output logic             nz_next
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic             do_inc;
    logic             do_dec;
    logic [CNT_W-1:0] occ_next;

    // Saturation guards keep the count inside 0..DEPTH even if a caller
    // presents an illegal inc/dec; the top-level checks flag that case.
    assign do_inc = inc && !dec && (occ != MAX_C);
    assign do_dec = dec && !inc && (occ != '0);

    always_comb begin
        occ_next = occ;
        if (do_inc) begin
            occ_next = occ + ONE_C;
        end else if (do_dec) begin
            occ_next = occ - ONE_C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            occ <= occ_next;
        end
    end

    assign full    = (occ == MAX_C);
    assign empty   = (occ == '0);
    assign nz_next = (occ_next != '0);

endmodule

// File: rtl/cj_join_stage.sv
// -----------------------------------------------------------------------------
// cj_join_stage
// Clocked successor of the self-timed CJ pipeline-control cell. Joins N_IN
// upstream Send/Ack channels, fires on all_req & G & Z_1 when there is room,
// holds up to DEPTH indistinguishable tokens, pulses CP once per accepted token
// to enable the external data latch and offers tokens downstream on
// Send_out/Ack_in. Control only: no data passes through this block.
//
// Ports:
//   CLK       in   stage clock
//   MR_n      in   master reset, asynchronous, active-low
//   Send_in   in   [N_IN] per-channel token request (level)
//   Ack_out   out  [N_IN] per-channel acknowledge, combinational accept pulse
//   G         in   gate; fires only when 1
//   Z_1       in   firing condition from the preceding stage
//   Send_out  out  downstream token valid (registered, high while Occ > 0)
//   Ack_in    in   downstream ready; transfer out = Send_out & Ack_in
//   CP        out  data-latch enable, registered, one cycle per token
//   Occ       out  [CNT_W] current token count
//   Drop      out  (CJ_DROP_EN only) registered discard indication
//   Full      out  Occ == DEPTH
//   Empty     out  Occ == 0
//
// Build option CJ_DROP_EN: with the gate closed (G=0) a complete, Z_1-qualified
// request is acknowledged and discarded instead of stalling; Drop pulses the
// cycle after. Without it, G=0 simply stalls the join.
// -----------------------------------------------------------------------------
module cj_join_stage
    import cj_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = cj_cnt_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             MR_n,
    input  logic [N_IN-1:0]  Send_in,
    output logic [N_IN-1:0]  Ack_out,
    input  logic             G,
    input  logic             Z_1,
    output logic             Send_out,
    input  logic             Ack_in,
    output logic             CP,
    output logic [CNT_W-1:0] Occ,
`ifdef CJ_DROP_EN
    output logic             Drop,
`endif
    output logic             Full,
    output logic             Empty
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (N_IN < 1 || N_IN > CJ_MAX_N_IN || DEPTH < 1 || DEPTH > CJ_MAX_DEPTH) begin : g_bad_param
        $error("cj_join_stage: N_IN or DEPTH out of supported range");
    end

    logic all_req;
    logic out_xfer;
    logic space;
    logic accept;
    logic ack_fire;
    logic nz_next;
    logic cp_p1;
    logic send_out_p1;

    // ---- stage 0: join, firing conditions and acknowledge -------------------
    assign all_req  = &Send_in;
    assign out_xfer = Send_out & Ack_in;
    // A full stage still accepts when a token leaves in the same cycle.
    assign space    = (Occ < DEPTH_C) | out_xfer;
    // MR_n in the term forces the combinational acks low during reset.
    assign accept   = all_req & G & Z_1 & space & MR_n;

`ifdef CJ_DROP_EN
    logic drop_fire;
    logic drop_p1;

    // A discard needs no room: the token never enters the stage.
    assign drop_fire = all_req & Z_1 & ~G & MR_n;
    assign ack_fire  = accept | drop_fire;
`else
    assign ack_fire  = accept;
`endif

    // All channels are acknowledged together; there are no partial acks.
    assign Ack_out = {N_IN{ack_fire}};

    cj_occ_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_occ (
        .clk     (CLK),
        .rst_n   (MR_n),
        .inc     (accept),
        .dec     (out_xfer),
        .occ     (Occ),
        .full    (Full),
        .empty   (Empty),
        .nz_next (nz_next)
    );

    // ---- stage 1: registered CP / Send_out / Drop ---------------------------
    // Send_out is registered from the next-state count, so it tracks Occ != 0
    // with a one-cycle accept-to-valid latency and never depends on Ack_in.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            cp_p1       <= 1'b0;
            send_out_p1 <= 1'b0;
        end else begin
            cp_p1       <= accept;
            send_out_p1 <= nz_next;
        end
    end

    assign CP       = cp_p1;
    assign Send_out = send_out_p1;

`ifdef CJ_DROP_EN
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            drop_p1 <= 1'b0;
        end else begin
            drop_p1 <= drop_fire;
        end
    end

    assign Drop = drop_p1;
`endif

    // ---- checks ---------------------------------------------------------------
    logic [1:0] st;

    always_comb begin
        st = CJ_ST_PARTIAL;
        if (Occ == '0) begin
            st = CJ_ST_EMPTY;
        end else if (Occ == DEPTH_C) begin
            st = CJ_ST_FULL;
        end
    end

    a_no_overflow : assert property (@(posedge CLK) disable iff (!MR_n)
        (Occ <= DEPTH_C) && !(accept && !out_xfer && Occ == DEPTH_C));

    a_no_underflow : assert property (@(posedge CLK) disable iff (!MR_n)
        !(out_xfer && Occ == '0));

    a_valid_tracks_occ : assert property (@(posedge CLK) disable iff (!MR_n)
        Send_out == (Occ != '0));

    a_full_holds : assert property (@(posedge CLK) disable iff (!MR_n)
        (st == CJ_ST_FULL && accept && out_xfer) |=> (st == CJ_ST_FULL));

endmodule

// File: tb/tb_cj_join_stage.sv
// -----------------------------------------------------------------------------
// tb_cj_join_stage
// Bench for cj_join_stage with N_IN=2, DEPTH=2: a directed vector table,
// hand-written reset sequences, then randomized traffic against a token-count
// reference model. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cj_join_stage;

    localparam int N_IN  = 2;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef CJ_DROP_EN
    localparam bit DROP_ON = 1'b1;
`else
    localparam bit DROP_ON = 1'b0;
`endif

    logic             clk;
    logic             mr_n;
    logic [N_IN-1:0]  send_in;
    logic [N_IN-1:0]  ack_out;
    logic             g;
    logic             z_1;
    logic             send_out;
    logic             ack_in;
    logic             cp;
    logic [CNT_W-1:0] occ;
    logic             full;
    logic             empty;
`ifdef CJ_DROP_EN
    logic             drop;
`endif

    cj_join_stage #(
        .N_IN  (N_IN),
        .DEPTH (DEPTH)
    ) dut (
        .CLK      (clk),
        .MR_n     (mr_n),
        .Send_in  (send_in),
        .Ack_out  (ack_out),
        .G        (g),
        .Z_1      (z_1),
        .Send_out (send_out),
        .Ack_in   (ack_in),
        .CP       (cp),
        .Occ      (occ),
`ifdef CJ_DROP_EN
        .Drop     (drop),
`endif
        .Full     (full),
        .Empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [N_IN-1:0] send;
        logic            g;
        logic            z;
        logic            a;
        logic [N_IN-1:0] ack;
        logic            cp;
        int              occ;
        logic            so;
        logic            drop;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [N_IN-1:0] s, input logic gg, input logic zz, input logic aa,
                       input logic [N_IN-1:0] ea, input logic ec, input int eo, input logic es,
                       input logic ed);
        vec_t v;
        v.send = s; v.g = gg; v.z = zz; v.a = aa;
        v.ack = ea; v.cp = ec; v.occ = eo; v.so = es; v.drop = ed;
        vq.push_back(v);
    endtask

    // Reference model state: token count and the one-cycle-late pulses.
    int m_occ;
    bit m_cp;
    bit m_drop;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N_IN-1:0] stall_ack;
        logic [N_IN-1:0] ones;
        ones = '1;
        stall_ack = DROP_ON ? ones : '0;

        // Directed table, starting from a freshly released reset.
        // send g z ack_in | ack cp occ send_out drop
        add(2'b11, 1, 1, 0, 2'b11, 0, 0, 0, 0);  // first accept
        add(2'b11, 1, 1, 0, 2'b11, 1, 1, 1, 0);  // second accept
        add(2'b11, 1, 1, 0, 2'b00, 1, 2, 1, 0);  // full: no ack
        add(2'b11, 1, 1, 0, 2'b00, 0, 2, 1, 0);
        add(2'b11, 1, 1, 1, 2'b11, 0, 2, 1, 0);  // full + drain -> accept
        add(2'b11, 1, 1, 1, 2'b11, 1, 2, 1, 0);
        add(2'b11, 1, 1, 1, 2'b11, 1, 2, 1, 0);
        add(2'b00, 1, 1, 1, 2'b00, 1, 2, 1, 0);  // drain only
        add(2'b00, 1, 1, 1, 2'b00, 0, 1, 1, 0);
        add(2'b00, 1, 1, 0, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)              // partial join never fires
            add(2'b01, 1, 1, 0, 2'b00, 0, 0, 0, 0);
        add(2'b11, 1, 1, 0, 2'b11, 0, 0, 0, 0);  // join completes
        add(2'b00, 1, 1, 0, 2'b00, 1, 1, 1, 0);  // Send_out rose
        add(2'b11, 0, 1, 0, stall_ack, 0, 1, 1, 0);        // gate closed
        add(2'b11, 0, 1, 0, stall_ack, 0, 1, 1, DROP_ON);
        add(2'b11, 0, 1, 0, stall_ack, 0, 1, 1, DROP_ON);
        add(2'b11, 1, 0, 0, 2'b00, 0, 1, 1, DROP_ON);      // Z_1 low stalls
        add(2'b11, 1, 1, 1, 2'b11, 0, 1, 1, 0);  // accept + drain at Occ=1
        add(2'b00, 1, 1, 1, 2'b00, 1, 1, 1, 0);
        add(2'b00, 1, 1, 1, 2'b00, 0, 0, 0, 0);

        // Reset held with every input high.
        mr_n = 1'b0; send_in = '1; g = 1'b1; z_1 = 1'b1; ack_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ack", int'(ack_out), 0);
            chk("rst_send_out", int'(send_out), 0);
            chk("rst_cp", int'(cp), 0);
            chk("rst_occ", int'(occ), 0);
            chk("rst_empty", int'(empty), 1);
            chk("rst_full", int'(full), 0);
        end

        // Table: release reset together with the first row.
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            mr_n = 1'b1;
            send_in = vq[i].send; g = vq[i].g; z_1 = vq[i].z; ack_in = vq[i].a;
            @(negedge clk);
            chk($sformatf("tbl%0d_ack", i), int'(ack_out), int'(vq[i].ack));
            chk($sformatf("tbl%0d_cp", i), int'(cp), int'(vq[i].cp));
            chk($sformatf("tbl%0d_occ", i), int'(occ), vq[i].occ);
            chk($sformatf("tbl%0d_send_out", i), int'(send_out), int'(vq[i].so));
            chk($sformatf("tbl%0d_full", i), int'(full), int'(vq[i].occ == DEPTH));
            chk($sformatf("tbl%0d_empty", i), int'(empty), int'(vq[i].occ == 0));
`ifdef CJ_DROP_EN
            chk($sformatf("tbl%0d_drop", i), int'(drop), int'(vq[i].drop));
`endif
        end

        // Mid-operation reset: fill to DEPTH, pulse MR_n low for half a cycle.
        @(posedge clk); #1;
        send_in = '1; g = 1'b1; z_1 = 1'b1; ack_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_pre_occ", int'(occ), DEPTH);
        mr_n = 1'b0;
        #1;
        chk("mid_rst_occ", int'(occ), 0);
        chk("mid_rst_send_out", int'(send_out), 0);
        chk("mid_rst_ack", int'(ack_out), 0);
        chk("mid_rst_cp", int'(cp), 0);
        @(negedge clk);
        mr_n = 1'b1;
        #1;
        chk("mid_rel_ack", int'(ack_out), int'(ones));
        @(posedge clk); #1;
        chk("mid_resume_occ", int'(occ), 1);
        chk("mid_resume_cp", int'(cp), 1);
        chk("mid_resume_send_out", int'(send_out), 1);

        // Randomized traffic against the token-count model.
        @(posedge clk); #1;
        mr_n = 1'b0; send_in = '0; g = 1'b0; z_1 = 1'b0; ack_in = 1'b0;
        @(negedge clk);
        mr_n = 1'b1;
        m_occ = 0; m_cp = 0; m_drop = 0;
        for (int c = 0; c < 400; c++) begin
            bit all, xfer, acc, drp;
            @(posedge clk); #1;
            send_in = ($urandom_range(0, 3) == 0) ? N_IN'($urandom) : ones;
            g       = ($urandom_range(0, 4) != 0);
            z_1     = ($urandom_range(0, 4) != 0);
            ack_in  = $urandom_range(0, 1);
            @(negedge clk);
            all  = (send_in == ones);
            xfer = (m_occ > 0) && ack_in;
            acc  = all && g && z_1 && ((m_occ < DEPTH) || xfer);
            drp  = DROP_ON && all && z_1 && !g;
            chk("rnd_ack", int'(ack_out), (acc || drp) ? int'(ones) : 0);
            chk("rnd_cp", int'(cp), int'(m_cp));
            chk("rnd_occ", int'(occ), m_occ);
            chk("rnd_send_out", int'(send_out), int'(m_occ > 0));
            chk("rnd_full", int'(full), int'(m_occ == DEPTH));
            chk("rnd_empty", int'(empty), int'(m_occ == 0));
`ifdef CJ_DROP_EN
            chk("rnd_drop", int'(drop), int'(m_drop));
`endif
            m_occ  = m_occ + int'(acc) - int'(xfer);
            m_cp   = acc;
            m_drop = drp;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cj_join_stage.md
Name: cj_join_stage

Overview:
- Clocked, parametrised successor of the self-timed CJ pipeline-control cell used in the data-driven processor (DDP) pipeline.
- Joins N_IN upstream Send/Ack channels and applies the firing conditions G and Z_1.
- Holds up to DEPTH in-flight tokens; issues a one-cycle CP pulse per accepted token to enable the external data latch, and hands tokens downstream on a Send_out/Ack_in channel.
- Control only: the data path stays outside the block.

Parameters:
- N_IN, 2, number of joined upstream channels (1..8).
- DEPTH, 2, maximum tokens held (1..16). DEPTH=1 reproduces the single-stage CJ behaviour.
- CNT_W, $clog2(DEPTH+1), occupancy width (derived; do not override).

Ports:
- CLK  in  1  stage clock.
- MR_n  in  1  master reset, asynchronous, active-low.
- Send_in  in  N_IN  per-channel token request; level, held by the sender until acknowledged.
- Ack_out  out  N_IN  per-channel acknowledge; one-cycle pulse in the accept cycle.
- G  in  1  gate; the token fires only when 1.
- Z_1  in  1  firing condition from the preceding stage; must be 1 to fire.
- Send_out  out  1  downstream token valid.
- Ack_in  in  1  downstream ready (level); transfer out = Send_out & Ack_in.
- CP  out  1  data-latch enable pulse, registered.
- Occ  out  CNT_W  current token count.
- Full  out  1  Occ==DEPTH.
- Empty  out  1  Occ==0.

Behaviour:
- Reset: one clock CLK; MR_n asynchronous active-low.
  - While MR_n=0: Occ=0, CP=0, Send_out=0, Empty=1, Full=0.
  - Ack_out is forced to 0 combinationally while MR_n=0.
  - Reset mid-operation discards all held tokens. A sender whose Ack was not pulsed keeps Send_in high.
- Join and accept:
  - all_req = &Send_in.
  - out_xfer = Send_out & Ack_in.
  - space = (Occ<DEPTH) | out_xfer, so a full stage accepts when it drains in the same cycle.
  - accept = all_req & G & Z_1 & space & MR_n.
  - Ack_out[i] = accept for every i. Acks are combinational and simultaneous on all channels; no partial acks.
- A partially asserted Send_in vector never fires. Channels that are already high stay unacked.
- CP is registered: CP=1 in the cycle after accept, exactly one cycle per token. Back-to-back accepts give CP high on consecutive cycles.
- Send_out = registered (Occ!=0); it is asserted the cycle after the first accept.
  - Accept-to-Send_out latency is 1 cycle.
  - Send_out stays high while Occ>0, independent of Ack_in.
- Occupancy update per cycle:
  - accept & !out_xfer: +1.
  - out_xfer & !accept: -1.
  - Both or neither: unchanged.
  - No wrap: Occ never exceeds DEPTH or goes below 0; assertions check both.
- Ordering is FIFO by construction (tokens are indistinguishable).
- G or Z_1 low: accept=0 and the stage stalls with no acks. Downstream draining continues.
- State: the implicit state machine is EMPTY (Occ=0) -> PARTIAL -> FULL (Occ=DEPTH). Transitions follow the Occ update above; FULL stays FULL on a simultaneous accept plus out_xfer.

Optional Feature:
- Macro: CJ_DROP_EN.
- Defined:
  - Adds output Drop (1 bit, registered, reset 0).
  - When all_req & Z_1 & !G, the inputs are acknowledged (Ack_out pulses) and the token is discarded.
  - Discard means no CP, no Occ change, and Drop=1 on the next cycle. Discard does not require space.
- Undefined: the Drop port is absent, and G=0 stalls as described above.

Decomposition:
- Package cj_pkg:
  - CJ_MAX_N_IN=8, CJ_MAX_DEPTH=16.
  - Function cj_cnt_w(depth).
  - Typedef cj_occ_t, sized for CJ_MAX_DEPTH.
- Sub-module cj_occ_counter: a saturating up/down counter with inc, dec, Occ, Full and Empty, async active-low reset.
- The top level holds the join/accept logic, CP/Send_out/Drop registers and assertions.

Test Plan:
- Reset: MR_n=0 with all inputs driven high -> Ack_out=0, Send_out=0, CP=0, Occ=0, Empty=1 throughout.
- Reset release, N_IN=2, Send_in=2'b11, G=1, Z_1=1, Ack_in=0, DEPTH=2:
  - Ack_out=2'b11 on cycles 0 and 1, CP high on cycles 1 and 2.
  - Occ=2, Full=1; no ack on cycle 2.
- Partial join: Send_in=2'b01 for 5 cycles -> no Ack_out, no CP.
  - Then Send_in=2'b11 -> Ack_out=2'b11 that cycle; Send_out rises next cycle.
- Full with simultaneous drain: Occ=2, Ack_in=1, Send_in=2'b11 held -> accept every cycle, Occ stays 2, CP continuous high.
- Gate stall: G=0 for 3 cycles with Send_in=2'b11 -> no Ack_out.
  - Under CJ_DROP_EN: 3 ack pulses, Drop high 3 cycles, Occ unchanged, CP=0.
- Mid-operation reset: Occ=2, pulse MR_n low for half a cycle -> Occ=0 immediately, Send_out=0; normal accept resumes on the next edge after release.
